// File: rtl/hex_seg_scan.sv
`default_nettype none
// ============================================================================
// hex_seg_scan : NDIG-deep hex digit history driving a multiplexed 7-seg display
// Optional feature macro: LEADING_ZERO_BLANK_EN            Revision: 1.0
// ============================================================================
module hex_seg_scan #(
  parameter int NDIG     = 4,
  parameter int SCAN_DIV = 4
) (
  input  logic            clk,
  input  logic            res,
  input  logic            ld,
  input  logic [3:0]      d,
  output logic [6:0]      seg,
  output logic [NDIG-1:0] an
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = $clog2(NDIG);
  localparam logic [PW-1:0] c_PRESC_LAST = PW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] c_IDX_LAST   = IW'(NDIG - 1);

  logic [3:0]      dig_q [NDIG];
  logic [3:0]      dig_d [NDIG];
  logic [NDIG-1:0] valid_q, valid_d;
  logic [PW-1:0]   presc_q, presc_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [6:0]      seg_q, seg_d;
  logic [NDIG-1:0] an_q, an_d;
  logic            presc_tc;
  logic [NDIG-1:0] blank;
  logic            upper_zero;

  function automatic logic [6:0] decode(input logic [3:0] v);
    case (v)
      4'h0: decode = 7'h3F;
      4'h1: decode = 7'h06;
      4'h2: decode = 7'h5B;
      4'h3: decode = 7'h4F;
      4'h4: decode = 7'h66;
      4'h5: decode = 7'h6D;
      4'h6: decode = 7'h7D;
      4'h7: decode = 7'h07;
      4'h8: decode = 7'h7F;
      4'h9: decode = 7'h6F;
      4'hA: decode = 7'h77;
      4'hB: decode = 7'h7C;
      4'hC: decode = 7'h39;
      4'hD: decode = 7'h5E;
      4'hE: decode = 7'h79;
      default: decode = 7'h71;
    endcase
  endfunction

  always_comb begin
    dig_d   = dig_q;
    valid_d = valid_q;
    if (ld) begin
      for (int i = NDIG - 1; i > 0; i--) begin
        dig_d[i] = dig_q[i-1];
      end
      dig_d[0] = d;
      valid_d  = {valid_q[NDIG-2:0], 1'b1};
    end

    presc_tc = (presc_q == c_PRESC_LAST);
    presc_d  = presc_tc ? '0 : presc_q + 1'b1;
    idx_d    = idx_q;
    if (presc_tc) begin
      idx_d = (idx_q == c_IDX_LAST) ? '0 : idx_q + 1'b1;
    end
  end

  // A digit is a leading zero when it and everything above it is zero or unloaded.
  always_comb begin
    blank      = '0;
    upper_zero = 1'b1;
`ifdef LEADING_ZERO_BLANK_EN
    for (int k = NDIG - 1; k >= 0; k--) begin
      if ((k > 0) && valid_q[k] && (dig_q[k] == 4'h0) && upper_zero) begin
        blank[k] = 1'b1;
      end
      upper_zero = upper_zero && (!valid_q[k] || (dig_q[k] == 4'h0));
    end
`endif
  end

  always_comb begin
    an_d  = NDIG'(1) << idx_q;
    seg_d = (valid_q[idx_q] && !blank[idx_q]) ? decode(dig_q[idx_q]) : 7'h00;
  end

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      for (int i = 0; i < NDIG; i++) begin
        dig_q[i] <= 4'h0;
      end
      valid_q <= '0;
      presc_q <= '0;
      idx_q   <= '0;
      seg_q   <= 7'h00;
      an_q    <= '0;
    end else begin
      dig_q   <= dig_d;
      valid_q <= valid_d;
      presc_q <= presc_d;
      idx_q   <= idx_d;
      seg_q   <= seg_d;
      an_q    <= an_d;
    end
  end

  assign seg = seg_q;
  assign an  = an_q;

endmodule
`default_nettype wire

// File: tb/tb_hex_seg_scan.sv
`default_nettype none
// ============================================================================
// tb_hex_seg_scan : bench for hex_seg_scan (NDIG=4, SCAN_DIV=4)   Revision: 1.0
// ============================================================================
module tb_hex_seg_scan;

  localparam int NDIG     = 4;
  localparam int SCAN_DIV = 4;
  localparam logic [6:0] DEC [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                      7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  logic            clk = 1'b0;
  logic            res = 1'b0;
  logic            ld  = 1'b0;
  logic [3:0]      d   = 4'h0;
  logic [6:0]      seg;
  logic [NDIG-1:0] an;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  hex_seg_scan #(.NDIG(NDIG), .SCAN_DIV(SCAN_DIV)) dut (
    .clk(clk), .res(res), .ld(ld), .d(d), .seg(seg), .an(an)
  );

  always #5 clk = ~clk;

  // Reference: loaded values newest-first, display slot derived from edge count.
  int              hist[$];
  int              tick;
  logic [6:0]      exp_seg;
  logic [NDIG-1:0] exp_an;

  function automatic logic [6:0] model_seg(input int k);
    int v;
    v = 0;
    if (k >= hist.size()) return 7'h00;
`ifdef LEADING_ZERO_BLANK_EN
    for (int i = 0; i < hist.size(); i++) v += hist[i] << (4 * i);
    if ((k > 0) && ((v >> (4 * k)) == 0)) return 7'h00;
`endif
    return DEC[hist[k]];
  endfunction

  always @(posedge clk or negedge res) begin
    if (!res) begin
      hist.delete();
      tick    <= 0;
      exp_seg <= 7'h00;
      exp_an  <= '0;
    end else begin
      exp_an  <= NDIG'(1) << ((tick / SCAN_DIV) % NDIG);
      exp_seg <= model_seg((tick / SCAN_DIV) % NDIG);
      if (ld) begin
        hist.push_front(int'(d));
        if (hist.size() > NDIG) void'(hist.pop_back());
      end
      tick <= tick + 1;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      checks++;
      if (seg !== exp_seg || an !== exp_an) begin
        errors++;
        $display("FAIL cycle_cmp t=%0t: seg=%h an=%b, expected seg=%h an=%b",
                 $time, seg, an, exp_seg, exp_an);
      end
    end
  end

  task automatic check_now(input logic [NDIG-1:0] tan, input logic [6:0] tseg, input string name);
    checks++;
    if (an !== tan || seg !== tseg) begin
      errors++;
      $display("FAIL %s: seg=%h an=%b, expected seg=%h an=%b", name, seg, an, tseg, tan);
    end
  endtask

  task automatic expect_slot(input logic [NDIG-1:0] tan, input logic [6:0] tseg, input string name);
    bit found;
    found = 1'b0;
    for (int n = 0; n < 64 && !found; n++) begin
      @(negedge clk);
      if (an === tan) found = 1'b1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL %s: slot an=%b never seen (timeout), last an=%b", name, tan, an);
    end else if (seg !== tseg) begin
      errors++;
      $display("FAIL %s: seg=%h, expected %h", name, seg, tseg);
    end
  endtask

  task automatic pulse_load(input logic [3:0] v);
    @(negedge clk);
    ld = 1'b1;
    d  = v;
    @(negedge clk);
    ld = 1'b0;
    d  = 4'bx;
  endtask

  task automatic do_reset;
    @(negedge clk);
    res = 1'b0;
    @(negedge clk);
    res = 1'b1;
  endtask

  initial begin
    bit hit;
    repeat (3) @(posedge clk);
    #1 chk_en = 1'b1;
    @(negedge clk);
    res = 1'b1;
    @(posedge clk);
    #1 check_now(4'b0001, 7'h00, "rst_first_edge");
    repeat (4) @(posedge clk);
    #1 check_now(4'b0010, 7'h00, "rst_slot1");

    pulse_load(4'h1);
    pulse_load(4'h2);
    pulse_load(4'h3);
    expect_slot(4'b0001, 7'h4F, "load_dig0");
    expect_slot(4'b0010, 7'h5B, "load_dig1");
    expect_slot(4'b0100, 7'h06, "load_dig2");
    expect_slot(4'b1000, 7'h00, "load_dig3_invalid");

    @(negedge clk);
    #2 res = 1'b0;
    #1 check_now('0, 7'h00, "rst_async");
    @(negedge clk);
    res = 1'b1;

    for (int v = 0; v < 16; v++) begin
      @(negedge clk);
      ld = 1'b1;
      d  = 4'(v);
    end
    @(negedge clk);
    ld = 1'b0;
    d  = 4'bx;
    expect_slot(4'b0001, 7'h71, "sweep_dig0_F");
    expect_slot(4'b0010, 7'h79, "sweep_dig1_E");

    do_reset();
    for (int v = 10; v < 15; v++) begin
      @(negedge clk);
      ld = 1'b1;
      d  = 4'(v);
    end
    @(negedge clk);
    ld = 1'b0;
    expect_slot(4'b1000, 7'h7C, "overflow_dig3_B");
    expect_slot(4'b0001, 7'h79, "overflow_dig0_E");

    hit = 1'b0;
    for (int n = 0; n < 64 && !hit; n++) begin
      @(negedge clk);
      if ((tick % (SCAN_DIV * NDIG)) == (SCAN_DIV * NDIG - 1)) hit = 1'b1;
    end
    if (!hit) begin
      checks++;
      errors++;
      $display("FAIL simul_align: wrap point not reached (timeout)");
    end else begin
      ld = 1'b1;
      d  = 4'h7;
      @(negedge clk);
      ld = 1'b0;
      @(negedge clk);
      check_now(4'b0001, 7'h07, "simul_load_and_wrap");
    end

    do_reset();
    pulse_load(4'h0);
    pulse_load(4'h0);
    pulse_load(4'h5);
`ifdef LEADING_ZERO_BLANK_EN
    expect_slot(4'b0100, 7'h00, "blank_dig2");
`else
    expect_slot(4'b0100, 7'h3F, "blank_dig2");
`endif
    expect_slot(4'b0001, 7'h6D, "blank_dig0");

    repeat (8) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
